// File: rtl/qic117_block_buffer.sv
// Two-bank 512-byte tape block store between QIC-117 streamer and DMA.
// Optional QIC_BUF_DROP_BAD_EN: discard blocks whose header is 8'hFF.
//
// Ports:
//   clk, reset_n        clock, async active-low reset
//   flush               sync clear of both banks and both FSMs
//   in_byte/in_valid    streamer byte and strobe
//   in_header           in_valid byte is the block header
//   in_block_num        block index, sampled with the header
//   in_block_done       block complete pulse
//   in_sync_lost        abort current block pulse
//   rd_valid/rd_ready   replay handshake
//   rd_data/first/last  replay byte and block framing
//   rd_header           header of block being read
//   rd_block_num        number of block being read
//   bank_full           per-bank committed flags
//   overflow_err        header arrived with no free bank
//   short_err           block ended with wrong byte count
//   drop_count          saturating discarded-block counter
module qic117_block_buffer #(
  parameter int BLOCK_BYTES = 512,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic [7:0]       in_byte,
  input  logic             in_valid,
  input  logic             in_header,
  input  logic [4:0]       in_block_num,
  input  logic             in_block_done,
  input  logic             in_sync_lost,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic [7:0]       rd_data,
  output logic             rd_first,
  output logic             rd_last,
  output logic [7:0]       rd_header,
  output logic [4:0]       rd_block_num,
  output logic [1:0]       bank_full,
  output logic             overflow_err,
  output logic             short_err,
  output logic [CNT_W-1:0] drop_count
);

  localparam int AW = $clog2(BLOCK_BYTES);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] FULL_CNT = PW'(BLOCK_BYTES);
  localparam logic [AW-1:0] LAST_IDX = AW'(BLOCK_BYTES - 1);

  typedef enum logic [1:0] {
    W_IDLE,
    W_FILL,
    W_DISCARD
  } wst_t;

  typedef enum logic [1:0] {
    R_IDLE,
    R_FETCH,
    R_STREAM
  } rst_t;

  logic [7:0] mem [2*BLOCK_BYTES];

  wst_t             w_state_q;
  logic             wbank_q;
  logic [PW-1:0]    wptr_q;
  logic [7:0]       hdr_q [2];
  logic [4:0]       bnum_q [2];
  logic             ovf_q;
  logic             short_q;
  logic [CNT_W-1:0] drop_q;
  logic [CNT_W-1:0] drop_d;
  logic [1:0]       full_q;

  rst_t             r_state_q;
  logic             rbank_q;
  logic [AW-1:0]    rptr_q;
  logic             rvalid_q;
  logic             rfirst_q;
  logic             rlast_q;
  logic [7:0]       rdata_q;
  logic [7:0]       rhdr_q;
  logic [4:0]       rbnum_q;

  logic          hdr_in;
  logic          dat_in;
  logic          full_len;
  logic          bad;
  logic          commit;
  logic          free_rd;
  logic          wr_en;
  logic          adv;
  logic          re;
  logic [AW:0]   waddr;
  logic [AW:0]   raddr;
  logic [1:0]    set_m;
  logic [1:0]    clr_m;

  assign hdr_in   = in_valid & in_header;
  assign dat_in   = in_valid & ~in_header;
  assign full_len = (wptr_q == FULL_CNT);
  assign drop_d   = (&drop_q) ? drop_q : drop_q + CNT_W'(1);

`ifdef QIC_BUF_DROP_BAD_EN
  assign bad = (hdr_q[wbank_q] == 8'hFF);
`else
  assign bad = 1'b0;
`endif

  // A block commits only when fully received and not preempted
  // by a higher-priority sync loss in the same cycle.
  assign commit = ~flush & (w_state_q == W_FILL) & ~in_sync_lost
                & in_block_done & full_len & ~bad;

  assign free_rd = ~flush & (r_state_q == R_STREAM)
                 & rvalid_q & rd_ready & rlast_q;

  // Bytes past the end of the block are dropped, not wrapped.
  assign wr_en = ~flush & (w_state_q == W_FILL) & ~in_sync_lost
               & ~in_block_done & dat_in & ~full_len;

  assign waddr = {wbank_q, wptr_q[AW-1:0]};

  // Prefetch: the output register advances only on a handshake,
  // so data stays stable while the consumer stalls.
  assign adv = (r_state_q == R_STREAM) & rvalid_q & rd_ready & ~rlast_q;
  assign re  = ~flush & ((r_state_q == R_FETCH) | adv);

  assign raddr = {rbank_q, (r_state_q == R_FETCH) ? AW'(0) : rptr_q};

  assign set_m = {commit & wbank_q, commit & ~wbank_q};
  assign clr_m = {free_rd & rbank_q, free_rd & ~rbank_q};

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[waddr] <= in_byte;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rdata_q <= '0;
    end else if (re) begin
      rdata_q <= mem[raddr];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      full_q <= '0;
    end else if (flush) begin
      full_q <= '0;
    end else begin
      full_q <= (full_q & ~clr_m) | set_m;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      w_state_q <= W_IDLE;
      wbank_q   <= 1'b0;
      wptr_q    <= '0;
      hdr_q[0]  <= '0;
      hdr_q[1]  <= '0;
      bnum_q[0] <= '0;
      bnum_q[1] <= '0;
      ovf_q     <= 1'b0;
      short_q   <= 1'b0;
      drop_q    <= '0;
    end else begin
      ovf_q   <= 1'b0;
      short_q <= 1'b0;
      if (flush) begin
        w_state_q <= W_IDLE;
        wbank_q   <= 1'b0;
        wptr_q    <= '0;
      end else begin
        unique case (w_state_q)
          W_IDLE: begin
            if (in_sync_lost || in_block_done) begin
              w_state_q <= W_IDLE;
            end else if (hdr_in) begin
              if (!full_q[wbank_q]) begin
                hdr_q[wbank_q]  <= in_byte;
                bnum_q[wbank_q] <= in_block_num;
                wptr_q          <= '0;
                w_state_q       <= W_FILL;
              end else begin
                ovf_q     <= 1'b1;
                drop_q    <= drop_d;
                w_state_q <= W_DISCARD;
              end
            end
          end
          W_FILL: begin
            if (in_sync_lost) begin
              drop_q    <= drop_d;
              w_state_q <= W_IDLE;
            end else if (in_block_done) begin
              if (!full_len) begin
                short_q <= 1'b1;
                drop_q  <= drop_d;
              end else if (bad) begin
                drop_q  <= drop_d;
              end else begin
                wbank_q <= ~wbank_q;
              end
              w_state_q <= W_IDLE;
            end else if (hdr_in) begin
              short_q         <= 1'b1;
              drop_q          <= drop_d;
              hdr_q[wbank_q]  <= in_byte;
              bnum_q[wbank_q] <= in_block_num;
              wptr_q          <= '0;
            end else if (dat_in && !full_len) begin
              wptr_q <= wptr_q + PW'(1);
            end
          end
          W_DISCARD: begin
            if (in_sync_lost || in_block_done) begin
              w_state_q <= W_IDLE;
            end
          end
          default: w_state_q <= W_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state_q <= R_IDLE;
      rbank_q   <= 1'b0;
      rptr_q    <= '0;
      rvalid_q  <= 1'b0;
      rfirst_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rhdr_q    <= '0;
      rbnum_q   <= '0;
    end else if (flush) begin
      r_state_q <= R_IDLE;
      rbank_q   <= 1'b0;
      rptr_q    <= '0;
      rvalid_q  <= 1'b0;
      rfirst_q  <= 1'b0;
      rlast_q   <= 1'b0;
    end else begin
      unique case (r_state_q)
        R_IDLE: begin
          if (full_q[rbank_q]) begin
            r_state_q <= R_FETCH;
          end
        end
        R_FETCH: begin
          rvalid_q  <= 1'b1;
          rfirst_q  <= 1'b1;
          rlast_q   <= 1'b0;
          rptr_q    <= AW'(1);
          rhdr_q    <= hdr_q[rbank_q];
          rbnum_q   <= bnum_q[rbank_q];
          r_state_q <= R_STREAM;
        end
        R_STREAM: begin
          if (rvalid_q && rd_ready) begin
            if (rlast_q) begin
              rvalid_q  <= 1'b0;
              rfirst_q  <= 1'b0;
              rlast_q   <= 1'b0;
              rbank_q   <= ~rbank_q;
              r_state_q <= R_IDLE;
            end else begin
              rfirst_q <= 1'b0;
              rlast_q  <= (rptr_q == LAST_IDX);
              rptr_q   <= rptr_q + AW'(1);
            end
          end
        end
        default: r_state_q <= R_IDLE;
      endcase
    end
  end

  assign rd_valid     = rvalid_q;
  assign rd_data      = rdata_q;
  assign rd_first     = rfirst_q;
  assign rd_last      = rlast_q;
  assign rd_header    = rhdr_q;
  assign rd_block_num = rbnum_q;
  assign bank_full    = full_q;
  assign overflow_err = ovf_q;
  assign short_err    = short_q;
  assign drop_count   = drop_q;

endmodule

// File: tb/tb_qic117_block_buffer.sv
// Randomized self-checking bench for qic117_block_buffer.
// Expected replay is built as a queue of blocks from the stimulus.
module tb_qic117_block_buffer;

  localparam int BB = 512;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          flush;
  logic [7:0]    in_byte;
  logic          in_valid;
  logic          in_header;
  logic [4:0]    in_block_num;
  logic          in_block_done;
  logic          in_sync_lost;
  logic          rd_valid;
  logic          rd_ready;
  logic [7:0]    rd_data;
  logic          rd_first;
  logic          rd_last;
  logic [7:0]    rd_header;
  logic [4:0]    rd_block_num;
  logic [1:0]    bank_full;
  logic          overflow_err;
  logic          short_err;
  logic [CW-1:0] drop_count;

  qic117_block_buffer #(.BLOCK_BYTES(BB), .CNT_W(CW)) dut (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .in_byte(in_byte), .in_valid(in_valid),
    .in_header(in_header), .in_block_num(in_block_num),
    .in_block_done(in_block_done), .in_sync_lost(in_sync_lost),
    .rd_valid(rd_valid), .rd_ready(rd_ready),
    .rd_data(rd_data), .rd_first(rd_first), .rd_last(rd_last),
    .rd_header(rd_header), .rd_block_num(rd_block_num),
    .bank_full(bank_full), .overflow_err(overflow_err),
    .short_err(short_err), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [22:0] got[$];
  logic [22:0] exp_q[$];
  logic [7:0]  blk [BB];
  int ovf_seen, short_seen, valid_seen, hold_viol;
  int model_drop, model_short;
  bit hold_prev;
  bit rand_rdy;
  logic [9:0] hold_val;

  always @(negedge clk) begin
    if (reset_n) begin
      if (rd_valid && rd_ready)
        got.push_back({rd_header, rd_block_num, rd_data, rd_first, rd_last});
      if (overflow_err) ovf_seen++;
      if (short_err) short_seen++;
      if (rd_valid) valid_seen++;
      if (hold_prev && {rd_valid, rd_data, rd_first, rd_last} !== {1'b1, hold_val})
        hold_viol++;
      hold_prev = rd_valid && !rd_ready;
      hold_val  = {rd_data, rd_first, rd_last};
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_rdy) rd_ready = 1'($urandom_range(1));
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0; flush = 1'b0; rand_rdy = 1'b0;
    in_byte = '0; in_valid = 1'b0; in_header = 1'b0;
    in_block_num = '0; in_block_done = 1'b0; in_sync_lost = 1'b0;
    rd_ready = 1'b0;
    tick(2);
    reset_n = 1'b1;
    tick(1);
    got.delete(); exp_q.delete();
    ovf_seen = 0; short_seen = 0; valid_seen = 0; hold_viol = 0;
    hold_prev = 1'b0; model_drop = 0; model_short = 0;
  endtask

  function automatic logic [CW-1:0] exp_drop();
    return (model_drop > 15) ? CW'(15) : CW'(model_drop);
  endfunction

  task automatic fill_rand();
    for (int i = 0; i < BB; i++) blk[i] = 8'($urandom);
  endtask

  task automatic add_exp(input logic [7:0] h, input logic [4:0] bn);
    for (int i = 0; i < BB; i++)
      exp_q.push_back({h, bn, blk[i], (i == 0), (i == BB - 1)});
  endtask

  task automatic send_hdr(input logic [7:0] h, input logic [4:0] bn);
    in_valid = 1'b1; in_header = 1'b1; in_byte = h; in_block_num = bn;
    tick();
    in_valid = 1'b0; in_header = 1'b0;
  endtask

  task automatic send_data(input int n, input bit gaps);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1; in_byte = blk[i];
      tick();
      in_valid = 1'b0;
      if (gaps && $urandom_range(7) == 0) tick($urandom_range(1, 3));
    end
  endtask

  task automatic pulse_done();
    in_block_done = 1'b1; tick(); in_block_done = 1'b0;
  endtask

  task automatic pulse_sync();
    in_sync_lost = 1'b1; tick(); in_sync_lost = 1'b0;
  endtask

  task automatic send_block(input logic [7:0] h, input logic [4:0] bn, input bit gaps);
    send_hdr(h, bn);
    send_data(BB, gaps);
    pulse_done();
  endtask

  task automatic wait_drain(input int budget, output bit to);
    to = 1'b1;
    for (int i = 0; i < budget; i++) begin
      if (got.size() >= exp_q.size() && !rd_valid && bank_full == 2'b00) begin
        to = 1'b0;
        break;
      end
      tick();
    end
  endtask

  function automatic int stream_errs();
    int e;
    e = (got.size() > exp_q.size()) ? got.size() - exp_q.size()
                                    : exp_q.size() - got.size();
    for (int i = 0; i < got.size() && i < exp_q.size(); i++)
      if (got[i] !== exp_q[i]) e++;
    return e;
  endfunction

  task automatic test_reset();
    do_reset();
    checks++;
    if ({rd_valid, rd_data, rd_first, rd_last, rd_header, rd_block_num} !== 24'h0) begin
      failures++;
      $display("FAIL reset_rd: got %h expected 0",
               {rd_valid, rd_data, rd_first, rd_last, rd_header, rd_block_num});
    end
    checks++;
    if ({bank_full, overflow_err, short_err, drop_count} !== 8'h0) begin
      failures++;
      $display("FAIL reset_status: got %h expected 0",
               {bank_full, overflow_err, short_err, drop_count});
    end
  endtask

  task automatic test_one_block();
    bit to;
    do_reset();
    rd_ready = 1'b1;
    for (int i = 0; i < BB; i++) blk[i] = 8'(i);
    send_hdr(8'h00, 5'd3);
    send_data(BB, 1'b0);
    add_exp(8'h00, 5'd3);
    pulse_done();
    checks++;
    if (bank_full !== 2'b01) begin
      failures++; $display("FAIL one_commit: got %b expected 01", bank_full);
    end
    tick();
    checks++;
    if (rd_valid !== 1'b0) begin
      failures++; $display("FAIL one_lat1: rd_valid got %b expected 0", rd_valid);
    end
    tick();
    checks++;
    if ({rd_valid, rd_first, rd_data} !== {1'b1, 1'b1, 8'h00}) begin
      failures++;
      $display("FAIL one_lat2: got %b/%b/%h expected 1/1/00", rd_valid, rd_first, rd_data);
    end
    wait_drain(2000, to);
    checks++;
    if (to !== 1'b0) begin
      failures++; $display("FAIL one_timeout: got %0d expected 0", to);
    end
    checks++;
    if (got.size() !== BB || stream_errs() !== 0) begin
      failures++;
      $display("FAIL one_stream: got %0d bytes errs %0d expected %0d errs 0",
               got.size(), stream_errs(), BB);
    end
    checks++;
    if (bank_full !== 2'b00) begin
      failures++; $display("FAIL one_free: got %b expected 00", bank_full);
    end
  endtask

  task automatic test_overflow();
    bit to;
    do_reset();
    for (int k = 0; k < 3; k++) begin
      fill_rand();
      send_block(8'(8'h10 + k), 5'(k), 1'b0);
      if (k < 2) add_exp(8'(8'h10 + k), 5'(k));
      else model_drop++;
    end
    tick(3);
    checks++;
    if ({bank_full, ovf_seen[3:0], drop_count} !== {2'b11, 4'd1, exp_drop()}) begin
      failures++;
      $display("FAIL ovf_state: got full %b ovf %0d drop %0d expected 11 1 %0d",
               bank_full, ovf_seen, drop_count, exp_drop());
    end
    rd_ready = 1'b1;
    wait_drain(3000, to);
    checks++;
    if (to !== 1'b0 || stream_errs() !== 0) begin
      failures++;
      $display("FAIL ovf_drain: to %0d errs %0d expected 0 0", to, stream_errs());
    end
  endtask

  task automatic test_short();
    do_reset();
    rd_ready = 1'b1;
    fill_rand();
    send_hdr(8'h33, 5'd2);
    send_data(100, 1'b0);
    pulse_done();
    model_drop++;
    tick(20);
    checks++;
    if ({short_seen[3:0], drop_count, bank_full} !== {4'd1, exp_drop(), 2'b00}) begin
      failures++;
      $display("FAIL short_state: got short %0d drop %0d full %b expected 1 %0d 00",
               short_seen, drop_count, bank_full, exp_drop());
    end
    checks++;
    if (valid_seen !== 0) begin
      failures++; $display("FAIL short_novalid: got %0d expected 0", valid_seen);
    end
  endtask

  task automatic test_sync_lost();
    bit to;
    do_reset();
    rd_ready = 1'b1;
    fill_rand();
    send_hdr(8'h5A, 5'd5);
    send_data(300, 1'b0);
    pulse_sync();
    model_drop++;
    fill_rand();
    send_block(8'hA5, 5'd9, 1'b1);
    add_exp(8'hA5, 5'd9);
    wait_drain(2000, to);
    checks++;
    if (to !== 1'b0 || stream_errs() !== 0) begin
      failures++;
      $display("FAIL sync_stream: to %0d errs %0d expected 0 0", to, stream_errs());
    end
    checks++;
    if ({drop_count, short_seen[3:0]} !== {exp_drop(), 4'd0}) begin
      failures++;
      $display("FAIL sync_drop: got drop %0d short %0d expected %0d 0",
               drop_count, short_seen, exp_drop());
    end
  endtask

  task automatic test_toggle();
    bit to;
    do_reset();
    for (int k = 0; k < 2; k++) begin
      fill_rand();
      send_block(8'(8'h40 + k), 5'(k + 1), 1'b0);
      add_exp(8'(8'h40 + k), 5'(k + 1));
    end
    to = 1'b1;
    for (int i = 0; i < 5000; i++) begin
      rd_ready = (i % 2 == 0);
      tick();
      if (got.size() >= exp_q.size() && !rd_valid && bank_full == 2'b00) begin
        to = 1'b0;
        break;
      end
    end
    checks++;
    if (to !== 1'b0 || stream_errs() !== 0) begin
      failures++;
      $display("FAIL toggle_stream: to %0d errs %0d expected 0 0", to, stream_errs());
    end
    checks++;
    if (hold_viol !== 0) begin
      failures++; $display("FAIL toggle_hold: got %0d violations expected 0", hold_viol);
    end
  endtask

  task automatic test_bad_marker();
    bit to;
    do_reset();
    rd_ready = 1'b1;
    fill_rand();
    send_block(8'hFF, 5'd4, 1'b0);
`ifdef QIC_BUF_DROP_BAD_EN
    model_drop++;
`else
    add_exp(8'hFF, 5'd4);
`endif
    wait_drain(2000, to);
    tick(5);
    checks++;
    if (to !== 1'b0 || stream_errs() !== 0) begin
      failures++;
      $display("FAIL bad_stream: to %0d errs %0d expected 0 0", to, stream_errs());
    end
    checks++;
    if ({drop_count, short_seen[3:0]} !== {exp_drop(), 4'd0}) begin
      failures++;
      $display("FAIL bad_drop: got drop %0d short %0d expected %0d 0",
               drop_count, short_seen, exp_drop());
    end
  endtask

  task automatic test_flush();
    bit to;
    do_reset();
    fill_rand();
    send_block(8'h11, 5'd1, 1'b0);
    tick(3);
    send_hdr(8'h12, 5'd2);
    send_data(50, 1'b0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checks++;
    if ({bank_full, rd_valid, drop_count} !== {2'b00, 1'b0, exp_drop()}) begin
      failures++;
      $display("FAIL flush_state: got full %b valid %b drop %0d expected 00 0 %0d",
               bank_full, rd_valid, drop_count, exp_drop());
    end
    fill_rand();
    send_block(8'h22, 5'd7, 1'b0);
    add_exp(8'h22, 5'd7);
    rd_ready = 1'b1;
    wait_drain(2000, to);
    checks++;
    if (to !== 1'b0 || stream_errs() !== 0) begin
      failures++;
      $display("FAIL flush_after: to %0d errs %0d expected 0 0", to, stream_errs());
    end
  endtask

  task automatic test_saturate();
    do_reset();
    for (int k = 0; k < 2; k++) begin
      fill_rand();
      send_block(8'(k), 5'(k), 1'b0);
    end
    for (int k = 0; k < 20; k++) begin
      send_hdr(8'(k), 5'(k));
      pulse_done();
      model_drop++;
    end
    tick(2);
    checks++;
    if ({ovf_seen[7:0], drop_count, bank_full} !== {8'd20, exp_drop(), 2'b11}) begin
      failures++;
      $display("FAIL sat_state: got ovf %0d drop %0d full %b expected 20 %0d 11",
               ovf_seen, drop_count, bank_full, exp_drop());
    end
  endtask

  task automatic test_random();
    bit to;
    int kind, n;
    logic [7:0] h;
    logic [4:0] bn;
    do_reset();
    rand_rdy = 1'b1;
    for (int b = 0; b < 8; b++) begin
      to = 1'b1;
      for (int i = 0; i < 3000; i++) begin
        if (bank_full != 2'b11) begin
          to = 1'b0;
          break;
        end
        tick();
      end
      if (to) begin
        checks++; failures++;
        $display("FAIL rand_wait: bank_full stuck %b expected free bank", bank_full);
        break;
      end
      kind = $urandom_range(3);
      h = 8'($urandom_range(254));
      bn = 5'($urandom);
      fill_rand();
      unique case (kind)
        0: begin
          send_block(h, bn, 1'b1);
          add_exp(h, bn);
        end
        1: begin
          n = $urandom_range(1, BB - 1);
          send_hdr(h, bn); send_data(n, 1'b1); pulse_done();
          model_drop++; model_short++;
        end
        2: begin
          n = $urandom_range(0, BB - 1);
          send_hdr(h, bn); send_data(n, 1'b1); pulse_sync();
          model_drop++;
        end
        default: begin
          n = $urandom_range(0, BB - 1);
          send_hdr(h, bn); send_data(n, 1'b1);
          model_drop++; model_short++;
          fill_rand();
          send_block(h ^ 8'h01, bn + 5'd1, 1'b1);
          add_exp(h ^ 8'h01, bn + 5'd1);
        end
      endcase
      tick($urandom_range(1, 4));
    end
    wait_drain(20000, to);
    rand_rdy = 1'b0;
    tick();
    checks++;
    if (to !== 1'b0 || stream_errs() !== 0) begin
      failures++;
      $display("FAIL rand_stream: to %0d errs %0d expected 0 0", to, stream_errs());
    end
    checks++;
    if ({drop_count, short_seen[7:0]} !== {exp_drop(), 8'(model_short)}) begin
      failures++;
      $display("FAIL rand_counts: got drop %0d short %0d expected %0d %0d",
               drop_count, short_seen, exp_drop(), model_short);
    end
  endtask

  initial begin
    test_reset();
    test_one_block();
    test_overflow();
    test_short();
    test_sync_lost();
    test_toggle();
    test_bad_marker();
    test_flush();
    test_saturate();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
